// File: rtl/router_ingress_port.sv
// Ingress stage for one router source port: validates byte-serial packets, buffers them
// store-and-forward, and releases only committed good packets to the switch core.
module router_ingress_port #(
    parameter int DEPTH      = 64,   // byte FIFO depth, power of 2, >= 16
    parameter int DESC_DEPTH = 4     // committed-packet descriptors, power of 2, >= 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        port_en,
    input  logic [7:0]  sa,
    input  logic        sa_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [7:0]  out_da,
    output logic [31:0] rx_pkt_cnt,
    output logic [31:0] crc_err_cnt,
    output logic [31:0] drop_cnt,
    output logic [2:0]  dbg_state
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int DW  = $clog2(DESC_DEPTH);
    localparam int DPW = DW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DROP    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;

    logic [2:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] base_ptr;
    logic [PW-1:0] fill;
    logic [31:0]   byte_cnt;
    logic [31:0]   len_q;
    logic [31:0]   crc_q;
    logic [31:0]   sum_q;
    logic [7:0]    da_q;
    logic [31:0]   rd_idx;

    logic [31:0]   desc_len [DESC_DEPTH];
    logic [7:0]    desc_da  [DESC_DEPTH];
    logic [DPW-1:0] desc_wr;
    logic [DPW-1:0] desc_rd;
    logic [DPW-1:0] desc_cnt;
    logic [31:0]   head_len;
    logic [7:0]    head_da;

    logic len_ok;
    logic da_ok;
    logic crc_ok;
    logic pass;
    logic push;
    logic desc_space;
    logic fifo_full;
    logic start_ok;
    logic in_pkt;
    logic wr_en;
    logic xfer;
    logic pop;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign dbg_state = state;

    // Write side. In CHECK a failed packet is rolled back in the same edge that may already
    // accept the next packet's first byte, so that byte lands at the rolled-back address.
    always_comb begin
        len_ok     = (byte_cnt == len_q) && (len_q >= 32'd10);
        da_ok      = (da_q >= 8'd1) && (da_q <= 8'd4);
        crc_ok     = (sum_q == crc_q);
        pass       = len_ok && da_ok && crc_ok;
        push       = (state == S_CHECK) && pass;
        base_ptr   = ((state == S_CHECK) && !pass) ? commit_ptr : wr_ptr;
        fill       = base_ptr - rd_ptr;
        fifo_full  = (fill == PW'(DEPTH));
        desc_space = (int'(desc_cnt) + int'(push)) < DESC_DEPTH;
        start_ok   = sa_valid && port_en && desc_space && !fifo_full;
        in_pkt     = (state == S_HDR) || (state == S_PAYLOAD);
        if ((state == S_IDLE) || (state == S_CHECK)) begin
            wr_en = start_ok;
        end else begin
            wr_en = in_pkt && sa_valid && !fifo_full;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            byte_cnt    <= '0;
            len_q       <= '0;
            crc_q       <= '0;
            sum_q       <= '0;
            da_q        <= '0;
            desc_wr     <= '0;
            rx_pkt_cnt  <= '0;
            crc_err_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= base_ptr + PW'(1);
            end
            case (state)
                S_IDLE, S_CHECK: begin
                    if (state == S_CHECK) begin
                        if (pass) begin
                            commit_ptr <= wr_ptr;
                            desc_wr    <= desc_wr + DPW'(1);
                            rx_pkt_cnt <= sat_inc(rx_pkt_cnt);
                        end else begin
                            if (!wr_en) begin
                                wr_ptr <= commit_ptr;
                            end
                            if (len_ok && da_ok) begin
                                crc_err_cnt <= sat_inc(crc_err_cnt);
                            end else begin
                                drop_cnt <= sat_inc(drop_cnt);
                            end
                        end
                    end
                    if (sa_valid) begin
                        if (start_ok) begin
                            byte_cnt <= 32'd1;
                            len_q    <= '0;
                            crc_q    <= '0;
                            sum_q    <= '0;
                            da_q     <= '0;
                            state    <= S_HDR;
                        end else begin
                            state <= S_DROP;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HDR: begin
                    if (!sa_valid) begin
                        state <= S_CHECK;
                    end else if (fifo_full) begin
                        state <= S_DROP;
                    end else begin
                        byte_cnt <= byte_cnt + 32'd1;
                        // Multi-byte fields arrive LSB first, so shift each byte in from the top.
                        case (byte_cnt[3:0])
                            4'd1:                      da_q  <= sa;
                            4'd2, 4'd3, 4'd4, 4'd5:    len_q <= {sa, len_q[31:8]};
                            4'd6, 4'd7, 4'd8, 4'd9:    crc_q <= {sa, crc_q[31:8]};
                            default: ;
                        endcase
                        if (byte_cnt == 32'd9) begin
                            state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (!sa_valid) begin
                        state <= S_CHECK;
                    end else if (fifo_full) begin
                        state <= S_DROP;
                    end else begin
                        byte_cnt <= byte_cnt + 32'd1;
                        sum_q    <= sum_q + {24'd0, sa};
                    end
                end
                S_DROP: begin
                    if (!sa_valid) begin
                        wr_ptr   <= commit_ptr;
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[base_ptr[AW-1:0]] <= sa;
        end
        if (push) begin
            desc_len[desc_wr[DW-1:0]] <= len_q;
            desc_da[desc_wr[DW-1:0]]  <= da_q;
        end
    end

    // Egress handshake: a byte moves on any rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, every out_* signal holds its value.
    always_comb begin
        desc_cnt  = desc_wr - desc_rd;
        head_len  = desc_len[desc_rd[DW-1:0]];
        head_da   = desc_da[desc_rd[DW-1:0]];
        out_valid = (desc_cnt != '0);
        out_sop   = out_valid && (rd_idx == 32'd0);
        out_eop   = out_valid && (rd_idx == head_len - 32'd1);
        out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'd0;
        out_da    = out_valid ? head_da : 8'd0;
        xfer      = out_valid && out_ready;
        pop       = xfer && out_eop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            rd_idx  <= '0;
            desc_rd <= '0;
        end else if (xfer) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (pop) begin
                rd_idx  <= 32'd0;
                desc_rd <= desc_rd + DPW'(1);
            end else begin
                rd_idx <= rd_idx + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_router_ingress_port.sv
// Self-checking bench for router_ingress_port: scenario tasks drive packets, a scoreboard
// queue holds the bytes each good packet must produce on the egress interface.
module tb_router_ingress_port;

  localparam int DEPTH      = 64;
  localparam int DESC_DEPTH = 4;
  localparam int W          = 18;  // {sop, eop, da, data}

  logic        clk = 1'b0;
  logic        reset;
  logic        port_en;
  logic [7:0]  sa;
  logic        sa_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  out_da;
  logic [31:0] rx_pkt_cnt;
  logic [31:0] crc_err_cnt;
  logic [31:0] drop_cnt;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           out_bytes = 0;
  logic [7:0]   pkt [256];
  int           pkt_n;
  logic [31:0]  exp_rx;
  logic [31:0]  exp_crc;
  logic [31:0]  exp_drop;

  always #5 clk = ~clk;

  router_ingress_port #(.DEPTH(DEPTH), .DESC_DEPTH(DESC_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .port_en    (port_en),
    .sa         (sa),
    .sa_valid   (sa_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_da     (out_da),
    .rx_pkt_cnt (rx_pkt_cnt),
    .crc_err_cnt(crc_err_cnt),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard consumer: compares each accepted byte and checks hold behaviour during stalls.
  task automatic monitor();
    logic [W-1:0] got;
    logic [W-1:0] expv;
    logic         prev_stall;
    logic [W:0]   prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if ({out_valid, out_sop, out_eop, out_da, out_data} !== prev_out) begin
            errors++;
            $display("FAIL stall_hold got=%h exp=%h", {out_valid, out_sop, out_eop, out_da, out_data}, prev_out);
          end
        end
        if (out_valid && out_ready) begin
          got = {out_sop, out_eop, out_da, out_data};
          checks++;
          out_bytes++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got=%h exp=none", got);
          end else begin
            expv = exp_q.pop_front();
            if (got !== expv) begin
              errors++;
              $display("FAIL out_byte got=%h exp=%h", got, expv);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, out_sop, out_eop, out_da, out_data};
      end
    end
  endtask

  task automatic build_pkt(input logic [7:0] s, input logic [7:0] d, input logic [31:0] len_f,
                           input int n_pay, input logic [7:0] p0, input logic [31:0] crc_delta);
    logic [31:0] sum;
    logic [31:0] crc;
    sum   = 32'd0;
    pkt_n = 10 + n_pay;
    for (int i = 0; i < n_pay; i++) begin
      pkt[10+i] = p0 + 8'(i);
      sum       = sum + {24'd0, pkt[10+i]};
    end
    crc    = sum + crc_delta;
    pkt[0] = s;
    pkt[1] = d;
    pkt[2] = len_f[7:0];
    pkt[3] = len_f[15:8];
    pkt[4] = len_f[23:16];
    pkt[5] = len_f[31:24];
    pkt[6] = crc[7:0];
    pkt[7] = crc[15:8];
    pkt[8] = crc[23:16];
    pkt[9] = crc[31:24];
  endtask

  task automatic send_pkt(input bit good);
    if (good) begin
      for (int i = 0; i < pkt_n; i++) begin
        exp_q.push_back({(i == 0), (i == pkt_n - 1), pkt[1], pkt[i]});
      end
    end
    for (int i = 0; i < pkt_n; i++) begin
      @(posedge clk); #1;
      sa       = pkt[i];
      sa_valid = 1'b1;
    end
    @(posedge clk); #1;
    sa_valid = 1'b0;
    sa       = 8'd0;
  endtask

  task automatic wait_drain(input bit rand_ready);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d_left exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; port_en = 1'b1; sa = 8'd0; sa_valid = 1'b0; out_ready = 1'b1;
    exp_rx = 0; exp_crc = 0; exp_drop = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, out_da, rx_pkt_cnt, crc_err_cnt, drop_cnt, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%b%b%b %h %h %h %h %h %h exp=all_zero", out_valid, out_sop, out_eop,
               out_data, out_da, rx_pkt_cnt, crc_err_cnt, drop_cnt, dbg_state);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_good();
    int start_bytes;
    start_bytes = out_bytes;
    out_ready   = 1'b1;
    build_pkt(8'd1, 8'd3, 32'h14, 10, 8'h01, 32'd0);
    send_pkt(1'b1);
    wait_drain(1'b0);
    exp_rx = exp_rx + 1;
    checks++;
    if (out_bytes - start_bytes != 20) begin
      errors++;
      $display("FAIL good_len got=%0d exp=20", out_bytes - start_bytes);
    end
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL good_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
  endtask

  task automatic test_crc_error();
    build_pkt(8'd1, 8'd3, 32'h14, 10, 8'h01, 32'd1);
    send_pkt(1'b0);
    wait_drain(1'b0);
    exp_crc = exp_crc + 1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL crc_valid got=%b exp=0", out_valid);
    end
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL crc_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
    build_pkt(8'd2, 8'd2, 32'h14, 10, 8'h20, 32'd0);
    send_pkt(1'b1);
    wait_drain(1'b0);
    exp_rx = exp_rx + 1;
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL crc_next_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
  endtask

  task automatic test_drop();
    build_pkt(8'd1, 8'd3, 32'h15, 10, 8'h01, 32'd0);
    send_pkt(1'b0);
    build_pkt(8'd1, 8'd5, 32'h14, 10, 8'h01, 32'd0);
    send_pkt(1'b0);
    port_en = 1'b0;
    build_pkt(8'd1, 8'd2, 32'h14, 10, 8'h01, 32'd0);
    send_pkt(1'b0);
    port_en = 1'b1;
    wait_drain(1'b0);
    exp_drop = exp_drop + 3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_valid got=%b exp=0", out_valid);
    end
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL drop_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
  endtask

  task automatic test_overflow();
    build_pkt(8'd1, 8'd4, 32'd72, 62, 8'h01, 32'd0);
    send_pkt(1'b0);
    build_pkt(8'd3, 8'd1, 32'h14, 10, 8'h40, 32'd0);
    send_pkt(1'b1);
    wait_drain(1'b0);
    exp_drop = exp_drop + 1;
    exp_rx   = exp_rx + 1;
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL ovf_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      build_pkt(8'(k + 1), 8'(k + 1), 32'd14, 4, 8'(16 * k + 1), 32'd0);
      send_pkt(1'b1);
    end
    build_pkt(8'd5, 8'd2, 32'd14, 4, 8'h70, 32'd0);
    send_pkt(1'b0);
    repeat (4) @(posedge clk);
    #1;
    exp_rx   = exp_rx + 4;
    exp_drop = exp_drop + 1;
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL b2b_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
    checks++;
    if ({out_valid, out_sop, out_da, out_data} !== {1'b1, 1'b1, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL b2b_head got=%b%b %h %h exp=11 01 01", out_valid, out_sop, out_da, out_data);
    end
    wait_drain(1'b1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    build_pkt(8'd1, 8'd2, 32'h14, 10, 8'h01, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      sa       = pkt[i];
      sa_valid = 1'b1;
    end
    @(posedge clk); #1;
    sa = pkt[7];
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, out_da, rx_pkt_cnt, crc_err_cnt, drop_cnt, dbg_state} !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%b%b%b %h %h %h %h %h %h exp=all_zero", out_valid, out_sop, out_eop,
               out_data, out_da, rx_pkt_cnt, crc_err_cnt, drop_cnt, dbg_state);
    end
    sa_valid = 1'b0;
    sa       = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    exp_rx   = 0;
    exp_crc  = 0;
    exp_drop = 0;
    @(posedge clk); #1;
    build_pkt(8'd4, 8'd4, 32'h14, 10, 8'h30, 32'd0);
    send_pkt(1'b1);
    wait_drain(1'b0);
    exp_rx = exp_rx + 1;
    checks++;
    if ({rx_pkt_cnt, crc_err_cnt, drop_cnt} !== {exp_rx, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL mid_reset_cnt got=%0d/%0d/%0d exp=%0d/%0d/%0d", rx_pkt_cnt, crc_err_cnt, drop_cnt, exp_rx, exp_crc, exp_drop);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_good();
    test_crc_error();
    test_drop();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
